// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: generates clk_en pulses for a stepped clock domain in manual, slow, fast or burst mode.
module clock_step_ctrl #(
  parameter int SLOW_LOG2 = 22,
  parameter int FAST_LOG2 = 2,
  parameter int DB_CYCLES = 50000,
  parameter int BURST_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_i,
  input  logic               manual_btn_i,
  input  logic               halt_i,
  input  logic               burst_go_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               clk_en_o,
  output logic [1:0]         mode_cur_o,
  output logic               burst_busy_o,
  output logic [31:0]        en_count_o
);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
  localparam logic [1:0] M_MANUAL = 2'b00, M_SLOW = 2'b01, M_FAST = 2'b10, M_BURST = 2'b11;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_s1_q, mode_s2_q, mode_cur_q, mode_cur_d;
  logic btn_s1_q, btn_s2_q, btn_s3_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic db_lvl_q, db_lvl_d, db_prev_q;
  logic [SLOW_LOG2-1:0] div_q, div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic clk_en_q, clk_en_d, busy_q;
  logic [31:0] en_count_q;
  logic mode_chg, go_ok, div_hit, man_hit;
  always_comb begin
    // mode is frozen while a burst runs and applied once the FSM is back in IDLE
    mode_cur_d = (state_q == IDLE) ? mode_s2_q : mode_cur_q;
    mode_chg = mode_cur_d != mode_cur_q;
    go_ok = burst_go_i && burst_len_i != '0 && state_q == IDLE && !halt_i &&
            mode_cur_q == M_BURST && mode_s2_q == M_BURST;
    div_hit = (mode_cur_q == M_SLOW && &div_q) || (mode_cur_q == M_FAST && &div_q[FAST_LOG2-1:0]);
    man_hit = mode_cur_q == M_MANUAL && db_lvl_q && !db_prev_q;
    state_d = state_q;
    rem_d = rem_q;
    if (go_ok) begin
      state_d = BURST;
      rem_d = burst_len_i;
    end else if (state_q == BURST && !halt_i) begin
      rem_d = rem_q - 1'b1;
      state_d = (rem_q == BURST_W'(1)) ? IDLE : BURST;
    end
    clk_en_d = !halt_i && !mode_chg && (state_q == BURST || div_hit || man_hit);
    div_d = mode_chg ? '0 : halt_i ? div_q : div_q + 1'b1;
    db_cnt_d = (btn_s2_q != btn_s3_q) ? '0 : (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
    db_lvl_d = (btn_s2_q == btn_s3_q && db_cnt_q == DB_MAX) ? btn_s2_q : db_lvl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      mode_cur_q <= M_MANUAL;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
      db_prev_q <= 1'b0;
      div_q <= '0;
      rem_q <= '0;
      clk_en_q <= 1'b0;
      busy_q <= 1'b0;
      en_count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_s1_q <= mode_i;
      mode_s2_q <= mode_s1_q;
      mode_cur_q <= mode_cur_d;
      btn_s1_q <= manual_btn_i;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
      db_prev_q <= db_lvl_q;
      div_q <= div_d;
      rem_q <= rem_d;
      clk_en_q <= clk_en_d;
      busy_q <= state_q == BURST;
      en_count_q <= en_count_q + {31'd0, clk_en_d};
    end
  end
  assign clk_en_o = clk_en_q;
  assign mode_cur_o = mode_cur_q;
  assign burst_busy_o = busy_q;
  assign en_count_o = en_count_q;
endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: directed scenario tests for clock_step_ctrl with small divider/debounce parameters.
module tb_clock_step_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode_i = 2'b00;
  logic manual_btn_i = 1'b0, halt_i = 1'b0, burst_go_i = 1'b0;
  logic [7:0] burst_len_i = 8'd0;
  logic clk_en_o, burst_busy_o;
  logic [1:0] mode_cur_o;
  logic [31:0] en_count_o;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  clock_step_ctrl #(.SLOW_LOG2(5), .FAST_LOG2(2), .DB_CYCLES(8), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .manual_btn_i(manual_btn_i), .halt_i(halt_i),
    .burst_go_i(burst_go_i), .burst_len_i(burst_len_i), .clk_en_o(clk_en_o),
    .mode_cur_o(mode_cur_o), .burst_busy_o(burst_busy_o), .en_count_o(en_count_o)
  );
  task automatic do_reset;
    rst = 1'b1;
    mode_i = 2'b00;
    manual_btn_i = 1'b0;
    halt_i = 1'b0;
    burst_go_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic set_mode(input logic [1:0] m);
    mode_i = m;
    repeat (4) @(negedge clk);
  endtask
  task automatic go(input logic [7:0] len);
    burst_len_i = len;
    burst_go_i = 1'b1;
    @(negedge clk);
    burst_go_i = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (clk_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_clk_en got %b want 0", clk_en_o); end
    n_cmp++; if (mode_cur_o !== 2'b00) begin n_bad++; $display("FAIL reset_mode_cur got %b want 00", mode_cur_o); end
    n_cmp++; if (burst_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", burst_busy_o); end
    n_cmp++; if (en_count_o !== 32'd0) begin n_bad++; $display("FAIL reset_en_count got %0d want 0", en_count_o); end
    rst = 1'b0;
  endtask
  task automatic test_fast;
    int cnt, first, last, bad_gap, b2b;
    logic prev;
    cnt = 0; first = -1; last = -1; bad_gap = 0; b2b = 0; prev = 1'b0;
    do_reset;
    set_mode(2'b10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clk_en_o) begin
        cnt++;
        if (first < 0) first = i;
        else if (i - last != 4) bad_gap++;
        last = i;
        if (prev) b2b++;
      end
      prev = clk_en_o;
    end
    n_cmp++; if (cnt != 10) begin n_bad++; $display("FAIL fast_count got %0d want 10", cnt); end
    n_cmp++; if (first != 2) begin n_bad++; $display("FAIL fast_first_phase got %0d want 2", first); end
    n_cmp++; if (bad_gap != 0 || b2b != 0) begin n_bad++; $display("FAIL fast_spacing got gaps=%0d b2b=%0d want 0/0", bad_gap, b2b); end
    n_cmp++; if (en_count_o !== 32'd10) begin n_bad++; $display("FAIL fast_en_count got %0d want 10", en_count_o); end
    n_cmp++; if (mode_cur_o !== 2'b10) begin n_bad++; $display("FAIL fast_mode_cur got %b want 10", mode_cur_o); end
  endtask
  task automatic test_manual;
    int cnt;
    cnt = 0;
    do_reset;
    for (int i = 0; i < 30; i++) begin
      manual_btn_i = ((i / 3) % 2) == 0;
      @(negedge clk);
      cnt += int'(clk_en_o);
    end
    manual_btn_i = 1'b1;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(clk_en_o);
    end
    n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL manual_press got %0d pulses want 1", cnt); end
    n_cmp++; if (en_count_o !== 32'd1) begin n_bad++; $display("FAIL manual_en_count got %0d want 1", en_count_o); end
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      manual_btn_i = ((i / 3) % 2) == 1;
      @(negedge clk);
      cnt += int'(clk_en_o);
    end
    manual_btn_i = 1'b0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(clk_en_o);
    end
    n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL manual_release got %0d pulses want 0", cnt); end
  endtask
  task automatic test_burst;
    int on, extra;
    on = 0; extra = 0;
    do_reset;
    set_mode(2'b11);
    go(8'd5);
    n_cmp++; if (clk_en_o !== 1'b0) begin n_bad++; $display("FAIL burst_latency got %b want 0", clk_en_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (clk_en_o && burst_busy_o) on++;
      burst_go_i = (i == 1);
      burst_len_i = 8'd3;
    end
    burst_go_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (on != 5) begin n_bad++; $display("FAIL burst_pulses got %0d want 5", on); end
    n_cmp++; if (clk_en_o !== 1'b0 || burst_busy_o !== 1'b0) begin n_bad++; $display("FAIL burst_end got en=%b busy=%b want 0/0", clk_en_o, burst_busy_o); end
    repeat (6) begin
      @(negedge clk);
      extra += int'(clk_en_o);
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL burst_mid_go got %0d extra pulses want 0", extra); end
    n_cmp++; if (en_count_o !== 32'd5) begin n_bad++; $display("FAIL burst_en_count got %0d want 5", en_count_o); end
    go(8'd0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      extra += int'(clk_en_o) + int'(burst_busy_o);
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL burst_len0 got %0d activity want 0", extra); end
    set_mode(2'b00);
    go(8'd4);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      extra += int'(clk_en_o) + int'(burst_busy_o);
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL burst_wrong_mode got %0d activity want 0", extra); end
  endtask
  task automatic test_mode_switch;
    int on, k;
    logic [1:0] m_last;
    on = 0; m_last = 2'b00;
    do_reset;
    set_mode(2'b11);
    go(8'd10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      on += int'(clk_en_o);
      if (i == 3) mode_i = 2'b01;
      m_last = mode_cur_o;
    end
    n_cmp++; if (on != 10) begin n_bad++; $display("FAIL switch_pulses got %0d want 10", on); end
    n_cmp++; if (m_last !== 2'b11) begin n_bad++; $display("FAIL switch_held_off got %b want 11", m_last); end
    @(negedge clk);
    n_cmp++; if (mode_cur_o !== 2'b01 || clk_en_o !== 1'b0) begin n_bad++; $display("FAIL switch_apply got mode=%b en=%b want 01/0", mode_cur_o, clk_en_o); end
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (clk_en_o) break;
    end
    n_cmp++; if (k != 32) begin n_bad++; $display("FAIL switch_slow_first got %0d cycles want 32", k); end
  endtask
  task automatic test_halt;
    int c1, ch, c2;
    c1 = 0; ch = 0; c2 = 0;
    do_reset;
    set_mode(2'b11);
    go(8'd6);
    repeat (3) begin
      @(negedge clk);
      c1 += int'(clk_en_o);
    end
    halt_i = 1'b1;
    repeat (7) begin
      @(negedge clk);
      ch += int'(clk_en_o);
    end
    halt_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      c2 += int'(clk_en_o);
    end
    n_cmp++; if (c1 != 3) begin n_bad++; $display("FAIL halt_before got %0d want 3", c1); end
    n_cmp++; if (ch != 0) begin n_bad++; $display("FAIL halt_during got %0d want 0", ch); end
    n_cmp++; if (c2 != 3) begin n_bad++; $display("FAIL halt_after got %0d want 3", c2); end
    n_cmp++; if (en_count_o !== 32'd6) begin n_bad++; $display("FAIL halt_en_count got %0d want 6", en_count_o); end
    n_cmp++; if (burst_busy_o !== 1'b0) begin n_bad++; $display("FAIL halt_busy_end got %b want 0", burst_busy_o); end
  endtask
  task automatic test_wrap;
    logic [31:0] v [3];
    do_reset;
    set_mode(2'b11);
    force dut.en_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.en_count_q;
    go(8'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v[i] = en_count_o;
    end
    n_cmp++; if (v[0] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_max got %h want ffffffff", v[0]); end
    n_cmp++; if (v[1] !== 32'd0) begin n_bad++; $display("FAIL wrap_zero got %h want 00000000", v[1]); end
    n_cmp++; if (v[2] !== 32'd1) begin n_bad++; $display("FAIL wrap_one got %h want 00000001", v[2]); end
  endtask
  task automatic test_rst_burst;
    int extra;
    extra = 0;
    do_reset;
    set_mode(2'b11);
    force dut.en_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.en_count_q;
    go(8'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    halt_i = 1'b1;
    burst_go_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (clk_en_o !== 1'b0 || burst_busy_o !== 1'b0) begin n_bad++; $display("FAIL rstb_en_busy got en=%b busy=%b want 0/0", clk_en_o, burst_busy_o); end
    n_cmp++; if (mode_cur_o !== 2'b00) begin n_bad++; $display("FAIL rstb_mode_cur got %b want 00", mode_cur_o); end
    n_cmp++; if (en_count_o !== 32'd0) begin n_bad++; $display("FAIL rstb_en_count got %h want 0", en_count_o); end
    rst = 1'b0;
    halt_i = 1'b0;
    burst_go_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      extra += int'(clk_en_o);
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL rstb_aborted got %0d pulses want 0", extra); end
  endtask
  initial begin
    do_reset;
    test_reset;
    test_fast;
    test_manual;
    test_burst;
    test_mode_switch;
    test_halt;
    test_wrap;
    test_rst_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
